// File: rtl/game_controller.sv
// Chip-invaders game sequencer: derives the frame tick from vsync, latches per-frame
// collisions, keeps score/lives/wave and runs the attract/play/death/wave/over FSM.
module game_controller #(
    parameter logic VS_POL        = 1'b1,
    parameter int   START_LIVES   = 3,
    parameter int   SCORE_PER_HIT = 1,
    parameter int   DEATH_FRAMES  = 60,
    parameter int   WAVE_FRAMES   = 60,
    parameter int   OVER_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       display_on,
    input  logic       laser_gfx,
    input  logic       alien_pixel,
    input  logic       cannon_gfx,
    input  logic       bomb_gfx,
    input  logic       aliens_cleared,
    input  logic       start,
    output logic [2:0] state,
    output logic       game_active,
    output logic       freeze,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [3:0] wave,
    output logic       hit_alien,
    output logic       formation_reset,
    output logic       cannon_reset
);

    typedef enum logic [2:0] {
        ST_ATTRACT    = 3'd0,
        ST_PLAYING    = 3'd1,
        ST_DYING      = 3'd2,
        ST_WAVE_CLEAR = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] WAVE_LAST  = 8'(WAVE_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

    state_t     state_q, state_d;
    logic       vsync_q, vs_edge, frame_tick;
    logic       laser_hit_f, player_hit_f;
    logic       laser_px, bomb_px, playing;
    logic [7:0] timer_q, timer_d;
    logic [7:0] score_d;
    logic [1:0] lives_d;
    logic [3:0] wave_d;
    logic       armed_q, armed_d;
    logic       form_d, cannon_d;
    logic [8:0] score_sum;

    assign vs_edge     = (vsync == VS_POL) && (vsync_q != VS_POL);
    assign playing     = (state_q == ST_PLAYING);
    assign laser_px    = display_on & laser_gfx & alien_pixel;
    assign bomb_px     = display_on & bomb_gfx & cannon_gfx;
    assign state       = state_q;
    assign game_active = playing;
    assign freeze      = ~playing;
    assign hit_alien   = laser_hit_f;

    // An overlap on the tick cycle itself belongs to the frame that is just starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            frame_tick   <= 1'b0;
            laser_hit_f  <= 1'b0;
            player_hit_f <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vs_edge;
            if (frame_tick) begin
                laser_hit_f  <= playing & laser_px;
                player_hit_f <= playing & bomb_px;
            end else begin
                laser_hit_f  <= laser_hit_f  | (playing & laser_px);
                player_hit_f <= player_hit_f | (playing & bomb_px);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        score_d   = score;
        lives_d   = lives;
        wave_d    = wave;
        armed_d   = armed_q;
        form_d    = 1'b0;
        cannon_d  = 1'b0;
        score_sum = {1'b0, score} + 9'(SCORE_PER_HIT);
        case (state_q)
            ST_ATTRACT: begin
                if (frame_tick) begin
                    if (start && armed_q) begin
                        state_d  = ST_PLAYING;
                        score_d  = 8'd0;
                        lives_d  = 2'(START_LIVES);
                        wave_d   = 4'd0;
                        form_d   = 1'b1;
                        cannon_d = 1'b1;
                        armed_d  = 1'b0;
                    end else if (!start) begin
                        armed_d = 1'b1;
                    end
                end
            end
            ST_PLAYING: begin
                if (frame_tick) begin
                    if (laser_hit_f)
                        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                    if (player_hit_f) begin
                        lives_d = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                        state_d = ST_DYING;
                    end else if (aliens_cleared) begin
                        wave_d  = wave + 4'd1;
                        state_d = ST_WAVE_CLEAR;
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (timer_q == DEATH_LAST) begin
                        state_d  = (lives == 2'd0) ? ST_GAME_OVER : ST_PLAYING;
                        cannon_d = (lives != 2'd0);
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            ST_WAVE_CLEAR: begin
                if (frame_tick) begin
                    if (timer_q == WAVE_LAST) begin
                        state_d = ST_PLAYING;
                        form_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (frame_tick) begin
                    if (timer_q == OVER_LAST) begin
                        state_d = ST_ATTRACT;
                        armed_d = 1'b0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
        // Every state entry restarts the frame timer.
        if (state_d != state_q)
            timer_d = 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_ATTRACT;
            timer_q         <= 8'd0;
            score           <= 8'd0;
            lives           <= 2'(START_LIVES);
            wave            <= 4'd0;
            armed_q         <= 1'b0;
            formation_reset <= 1'b0;
            cannon_reset    <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            score           <= score_d;
            lives           <= lives_d;
            wave            <= wave_d;
            armed_q         <= armed_d;
            formation_reset <= form_d;
            cannon_reset    <= cannon_d;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: frame-level reference model driven by
// a vector table, directed multi-frame sequences and randomized frames.
module tb_game_controller;

    localparam int ACT       = 12;
    localparam int S_ATTRACT = 0;
    localparam int S_PLAYING = 1;
    localparam int S_DYING   = 2;
    localparam int S_WAVE    = 3;
    localparam int S_OVER    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       display_on;
    logic       laser_gfx;
    logic       alien_pixel;
    logic       cannon_gfx;
    logic       bomb_gfx;
    logic       aliens_cleared;
    logic       start;
    logic [2:0] state;
    logic       game_active;
    logic       freeze;
    logic [7:0] score;
    logic [1:0] lives;
    logic [3:0] wave;
    logic       hit_alien;
    logic       formation_reset;
    logic       cannon_reset;

    game_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vsync           (vsync),
        .display_on      (display_on),
        .laser_gfx       (laser_gfx),
        .alien_pixel     (alien_pixel),
        .cannon_gfx      (cannon_gfx),
        .bomb_gfx        (bomb_gfx),
        .aliens_cleared  (aliens_cleared),
        .start           (start),
        .state           (state),
        .game_active     (game_active),
        .freeze          (freeze),
        .score           (score),
        .lives           (lives),
        .wave            (wave),
        .hit_alien       (hit_alien),
        .formation_reset (formation_reset),
        .cannon_reset    (cannon_reset)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame-level reference: one call per vsync, timed states count down.
    int m_state, m_score, m_lives, m_wave, m_left, m_fr, m_cr;
    bit m_armed;

    typedef struct {
        int laser_n;
        int bomb_n;
        bit disp;
        bit clr;
        bit st;
        int e_state;
        int e_score;
        int e_lives;
        int e_wave;
        int e_fr;
        int e_cr;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        m_state = S_ATTRACT;
        m_score = 0;
        m_lives = 3;
        m_wave  = 0;
        m_left  = 0;
        m_armed = 1'b0;
        m_fr    = 0;
        m_cr    = 0;
    endfunction

    function automatic void modelTick(input bit laser_hit, input bit player_hit,
                                      input bit cleared, input bit st);
        m_fr = 0;
        m_cr = 0;
        case (m_state)
            S_ATTRACT: begin
                if (st && m_armed) begin
                    m_state = S_PLAYING;
                    m_score = 0;
                    m_lives = 3;
                    m_wave  = 0;
                    m_fr    = 1;
                    m_cr    = 1;
                    m_armed = 1'b0;
                end else if (!st) begin
                    m_armed = 1'b1;
                end
            end
            S_PLAYING: begin
                if (laser_hit)
                    m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
                if (player_hit) begin
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    m_state = S_DYING;
                    m_left  = 60;
                end else if (cleared) begin
                    m_wave  = (m_wave + 1) % 16;
                    m_state = S_WAVE;
                    m_left  = 60;
                end
            end
            S_DYING: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) begin
                        m_state = S_OVER;
                        m_left  = 180;
                    end else begin
                        m_state = S_PLAYING;
                        m_cr    = 1;
                    end
                end
            end
            S_WAVE: begin
                m_left--;
                if (m_left == 0) begin
                    m_state = S_PLAYING;
                    m_fr    = 1;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_state = S_ATTRACT;
                    m_armed = 1'b0;
                end
            end
        endcase
    endfunction

    // One frame: active region with overlap windows and noise, then a vsync pulse.
    task automatic applyStimulus(input int laser_n, input int bomb_n, input bit disp,
                                 input bit clr, input bit st,
                                 output int fr_cnt, output int cr_cnt);
        bit exp_laser, exp_player, hit_v0, hit_v1;
        int first_hit;
        exp_laser  = disp && (laser_n > 0) && (m_state == S_PLAYING);
        exp_player = disp && (bomb_n > 0) && (m_state == S_PLAYING);
        first_hit  = -1;
        fr_cnt     = 0;
        cr_cnt     = 0;
        hit_v0     = 1'b0;
        hit_v1     = 1'b0;
        aliens_cleared = clr;
        start          = st;
        display_on     = disp;
        vsync          = 1'b0;
        for (int i = 0; i < ACT; i++) begin
            @(posedge clk); #1;
            if (hit_alien && first_hit < 0)
                first_hit = i;
            fr_cnt += int'(formation_reset);
            cr_cnt += int'(cannon_reset);
            alien_pixel = (i >= 2 && i < 2 + laser_n);
            laser_gfx   = alien_pixel ? 1'b1 : 1'($urandom_range(0, 1));
            bomb_gfx    = (i >= 6 && i < 6 + bomb_n);
            cannon_gfx  = bomb_gfx ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        fr_cnt += int'(formation_reset);
        cr_cnt += int'(cannon_reset);
        laser_gfx   = 1'b0;
        alien_pixel = 1'b0;
        bomb_gfx    = 1'b0;
        cannon_gfx  = 1'b0;
        vsync       = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            fr_cnt += int'(formation_reset);
            cr_cnt += int'(cannon_reset);
            if (j == 0) hit_v0 = hit_alien;
            if (j == 1) hit_v1 = hit_alien;
        end
        vsync = 1'b0;
        modelTick(exp_laser, exp_player, clr, st);
        checkOutput("state", int'(state), m_state);
        checkOutput("score", int'(score), m_score);
        checkOutput("lives", int'(lives), m_lives);
        checkOutput("wave", int'(wave), m_wave);
        checkOutput("game_active", int'(game_active), int'(m_state == S_PLAYING));
        checkOutput("freeze", int'(freeze), int'(m_state != S_PLAYING));
        checkOutput("formation_reset_cycles", fr_cnt, m_fr);
        checkOutput("cannon_reset_cycles", cr_cnt, m_cr);
        checkOutput("hit_rise_cycle", first_hit, exp_laser ? 3 : -1);
        checkOutput("hit_at_tick", int'(hit_v0), int'(exp_laser));
        checkOutput("hit_after_tick", int'(hit_v1), 0);
    endtask

    int fr, cr;

    initial begin
        vecs[0] = '{0, 0, 1'b1, 1'b0, 1'b0, S_ATTRACT, 0, 3, 0, 0, 0};
        vecs[1] = '{0, 0, 1'b1, 1'b0, 1'b0, S_ATTRACT, 0, 3, 0, 0, 0};
        vecs[2] = '{0, 0, 1'b1, 1'b0, 1'b1, S_PLAYING, 0, 3, 0, 1, 1};
        vecs[3] = '{5, 0, 1'b1, 1'b0, 1'b0, S_PLAYING, 1, 3, 0, 0, 0};
        vecs[4] = '{3, 0, 1'b0, 1'b0, 1'b0, S_PLAYING, 1, 3, 0, 0, 0};
        vecs[5] = '{2, 1, 1'b1, 1'b0, 1'b0, S_DYING,   2, 2, 0, 0, 0};
        vecs[6] = '{3, 1, 1'b1, 1'b1, 1'b0, S_DYING,   2, 2, 0, 0, 0};

        rst_n          = 1'b0;
        vsync          = 1'b0;
        display_on     = 1'b0;
        laser_gfx      = 1'b0;
        alien_pixel    = 1'b0;
        cannon_gfx     = 1'b0;
        bomb_gfx       = 1'b0;
        aliens_cleared = 1'b0;
        start          = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", int'(state), S_ATTRACT);
        checkOutput("reset_lives", int'(lives), 3);
        checkOutput("reset_score", int'(score), 0);
        checkOutput("reset_freeze", int'(freeze), 1);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k].laser_n, vecs[k].bomb_n, vecs[k].disp,
                          vecs[k].clr, vecs[k].st, fr, cr);
            checkOutput("tbl_state", int'(state), vecs[k].e_state);
            checkOutput("tbl_score", int'(score), vecs[k].e_score);
            checkOutput("tbl_lives", int'(lives), vecs[k].e_lives);
            checkOutput("tbl_wave", int'(wave), vecs[k].e_wave);
            checkOutput("tbl_fr", fr, vecs[k].e_fr);
            checkOutput("tbl_cr", cr, vecs[k].e_cr);
        end

        // Dying lasts exactly 60 ticks, then the cannon is recentred.
        repeat (58) applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        checkOutput("dying_tick59_state", int'(state), S_DYING);
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        checkOutput("dying_exit_state", int'(state), S_PLAYING);
        checkOutput("dying_exit_cr", cr, 1);

        // Cleared formation plus player hit: death wins, wave untouched.
        applyStimulus(0, 1, 1'b1, 1'b1, 1'b0, fr, cr);
        checkOutput("clr_hit_state", int'(state), S_DYING);
        checkOutput("clr_hit_wave", int'(wave), 0);
        checkOutput("clr_hit_lives", int'(lives), 1);
        repeat (60) applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);

        applyStimulus(0, 0, 1'b1, 1'b1, 1'b0, fr, cr);
        checkOutput("wave_state", int'(state), S_WAVE);
        checkOutput("wave_count", int'(wave), 1);
        repeat (59) applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        checkOutput("wave_exit_state", int'(state), S_PLAYING);
        checkOutput("wave_exit_fr", fr, 1);

        repeat (256) applyStimulus(1, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        checkOutput("score_saturated", int'(score), 255);

        // Last life lost with start held high the whole way through game over.
        applyStimulus(0, 1, 1'b1, 1'b0, 1'b1, fr, cr);
        checkOutput("last_life", int'(lives), 0);
        repeat (60) applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, fr, cr);
        checkOutput("over_state", int'(state), S_OVER);
        repeat (179) applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, fr, cr);
        checkOutput("over_tick179_state", int'(state), S_OVER);
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, fr, cr);
        checkOutput("over_exit_state", int'(state), S_ATTRACT);
        checkOutput("over_held_score", int'(score), 255);
        repeat (5) applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, fr, cr);
        checkOutput("held_start_state", int'(state), S_ATTRACT);
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, fr, cr);
        checkOutput("restart_state", int'(state), S_PLAYING);
        checkOutput("restart_score", int'(score), 0);
        checkOutput("restart_lives", int'(lives), 3);

        // Asynchronous reset in the middle of a death sequence.
        applyStimulus(1, 1, 1'b1, 1'b0, 1'b0, fr, cr);
        repeat (5) applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_state", int'(state), S_ATTRACT);
        checkOutput("async_score", int'(score), 0);
        checkOutput("async_lives", int'(lives), 3);
        checkOutput("async_wave", int'(wave), 0);
        checkOutput("async_hit", int'(hit_alien), 0);
        checkOutput("async_fr", int'(formation_reset), 0);
        checkOutput("async_cr", int'(cannon_reset), 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, fr, cr);

        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom_range(0, 5),
                          ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2) : 0,
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)),
                          fr, cr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
